// File: rtl/alu_sequencer_pkg.sv
// Shared opcodes, compare function codes, FSM states and flag payload for alu_sequencer.
package alu_sequencer_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_CMPEQ = 3'b010;
    localparam logic [2:0] OP_CMPLT = 3'b011;
    localparam logic [2:0] OP_CMPLE = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;

    localparam logic [1:0] CMP_NONE = 2'b00;
    localparam logic [1:0] CMP_EQ   = 2'b01;
    localparam logic [1:0] CMP_LT   = 2'b10;
    localparam logic [1:0] CMP_LE   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul_step.sv
// Shift-add multiplier datapath registers; the accumulator is updated from the shared adder.
module alu_seq_mul_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mcand,
    output logic             mplier_lsb
);

    logic [WIDTH-1:0] mplier;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (step) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign mplier_lsb = mplier[0];

endmodule

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit adder built from per-bit generate/propagate terms.
module carry_lookahead_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             carry;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i] = p[i] ^ carry;
            carry  = g[i] | (p[i] & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/compare_unit.sv
// Signed compare decision from the flags of A-B.
module compare_unit
    import alu_sequencer_pkg::*;
(
    input  logic [1:0] alu_fn,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       b_o
);

    always_comb begin
        b_o = 1'b0;
        case (alu_fn)
            CMP_EQ:  b_o = z;
            CMP_LT:  b_o = n ^ v;
            CMP_LE:  b_o = z | (n ^ v);
            default: b_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/zvn.sv
// Zero / signed-overflow / negative flags for an adder result.
module zvn #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             cout,
    output logic             z,
    output logic             v,
    output logic             n
);

    // Carry into the sign bit recovered from the sign-bit sum.
    logic c_msb;

    assign c_msb = a_msb ^ b_msb ^ sum[WIDTH-1];
    assign z     = (sum == '0);
    assign v     = c_msb ^ cout;
    assign n     = sum[WIDTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU front end: sequences one shared adder for add/sub/compare and shift-add multiply.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_z,
    output logic             o_v,
    output logic             o_n,
    output logic             o_err
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

    logic [WIDTH-1:0] add_a, add_b, sum;
    logic             cin, cout;
    logic             z_c, v_c, n_c;
    logic [1:0]       cmp_fn;
    logic             cmp_bit;

    logic [WIDTH-1:0] acc, mcand;
    logic             mplier_lsb, mul_load, mul_step;

    logic [WIDTH-1:0] result_d;
    flags_t           flags_d, flags_q;
    logic             valid_d, ready_d;

    carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
        .a(add_a), .b(add_b), .cin(cin), .sum(sum), .cout(cout)
    );

    zvn #(.WIDTH(WIDTH)) u_zvn (
        .sum(sum), .a_msb(add_a[WIDTH-1]), .b_msb(add_b[WIDTH-1]), .cout(cout),
        .z(z_c), .v(v_c), .n(n_c)
    );

    compare_unit u_cmp (
        .alu_fn(cmp_fn), .z(z_c), .v(v_c), .n(n_c), .b_o(cmp_bit)
    );

    alu_seq_mul_step #(.WIDTH(WIDTH)) u_mul (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .load(mul_load), .step(mul_step),
        .a(i_a), .b(i_b), .sum(sum),
        .acc(acc), .mcand(mcand), .mplier_lsb(mplier_lsb)
    );

    assign accept = (state == S_IDLE) && o_ready && i_valid;

    // Next state, adder steering and next registered outputs.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt_q;
        add_a    = '0;
        add_b    = '0;
        cin      = 1'b0;
        cmp_fn   = CMP_NONE;
        mul_load = 1'b0;
        mul_step = 1'b0;
        result_d = o_result;
        flags_d  = flags_q;
        valid_d  = o_valid;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    mul_load = (i_op == OP_MUL);
                    state_d  = (i_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                state_d  = S_DONE;
                valid_d  = 1'b1;
                result_d = '0;
                flags_d  = '0;
                if (op_q <= OP_CMPLE) begin
                    cin   = (op_q == OP_ADD || op_q == OP_SUB) ? op_q[0] : 1'b1;
                    add_a = a_q;
                    add_b = b_q ^ {WIDTH{cin}};
                    case (op_q)
                        OP_CMPEQ: cmp_fn = CMP_EQ;
                        OP_CMPLT: cmp_fn = CMP_LT;
                        OP_CMPLE: cmp_fn = CMP_LE;
                        default:  cmp_fn = CMP_NONE;
                    endcase
                    result_d  = (cmp_fn == CMP_NONE) ? sum : WIDTH'(cmp_bit);
                    flags_d.z = z_c;
                    flags_d.v = v_c;
                    flags_d.n = n_c;
                end else begin
                    flags_d.err = 1'b1;
                end
            end
            S_MUL: begin
                add_a    = acc;
                add_b    = mplier_lsb ? mcand : '0;
                mul_step = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d     = '0;
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    result_d  = sum;
                    flags_d   = '0;
                    flags_d.z = (sum == '0);
                    flags_d.n = sum[WIDTH-1];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready_d = (state_d == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            o_result <= '0;
            flags_q  <= '0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt_q    <= cnt_d;
            o_result <= result_d;
            flags_q  <= flags_d;
            o_valid  <= valid_d;
            o_ready  <= ready_d;
            if (accept) begin
                op_q <= i_op;
                a_q  <= i_a;
                b_q  <= i_b;
            end
        end
    end

    assign o_z   = flags_q.z;
    assign o_v   = flags_q.v;
    assign o_n   = flags_q.n;
    assign o_err = flags_q.err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer (WIDTH=16).
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int unsigned WIDTH = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [2:0]       i_op = 3'b000;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] o_result;
    logic             o_z, o_v, o_n, o_err;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_z(o_z), .o_v(o_v), .o_n(o_n), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] res,
                           input logic z, input logic v, input logic n, input logic err);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_result"}, 32'(o_result), 32'(res));
        chk({tag, "_zvne"}, 32'({o_z, o_v, o_n, o_err}), 32'({z, v, n, err}));
    endtask

    // Called at a negedge; returns just after the accept edge.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit hold);
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1;
        if (hold) begin
            i_op = OP_SUB;
            i_a  = 16'h5A5A;
            i_b  = 16'h0101;
        end else begin
            i_valid = 1'b0;
        end
    endtask

    // Counts edges after the accept edge until o_valid is seen; ends at a negedge.
    task automatic wait_valid(input string tag, input int exp_lat);
        int edges = 0;
        bit seen  = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(posedge i_clk);
            edges++;
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    endtask

    // Called at a negedge with o_valid high; consumes the result.
    task automatic take(input string tag);
        i_ready = 1'b1;
        i_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        chk({tag, "_idle"}, 32'({o_valid, o_ready}), 32'b01);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_out", 32'({o_valid, o_result, o_z, o_v, o_n, o_err}), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);

        // ADD with signed overflow
        send(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        @(negedge i_clk);
        chk("add_busy", 32'({o_valid, o_ready}), 32'b00);
        @(posedge i_clk);
        @(negedge i_clk);
        chk_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        take("add_ovf");

        // SUB with 5 cycles of back-pressure
        send(OP_SUB, 16'h0101, 16'h0011, 1'b0);
        wait_valid("sub", 1);
        for (int i = 0; i < 5; i++) begin
            chk_out("sub_hold", 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("sub_hold_ready", 32'(o_ready), 32'd0);
            @(negedge i_clk);
        end
        take("sub");

        // Signed compares
        send(OP_CMPLT, 16'hA234, 16'h8000, 1'b0);
        wait_valid("lt0", 1);
        chk("lt0_result", 32'(o_result), 32'h0000);
        take("lt0");

        send(OP_CMPLT, 16'hFFFF, 16'h0001, 1'b0);
        wait_valid("lt1", 1);
        chk_out("lt1", 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        take("lt1");

        send(OP_CMPEQ, 16'hC0FF, 16'hC0FF, 1'b0);
        wait_valid("eq", 1);
        chk_out("eq", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        take("eq");

        send(OP_CMPLE, 16'hC0FF, 16'hEECC, 1'b0);
        wait_valid("le", 1);
        chk("le_result", 32'(o_result), 32'h0001);
        take("le");

        // Multiply
        send(OP_MUL, 16'h0123, 16'h0010, 1'b0);
        wait_valid("mul0", 16);
        chk_out("mul0", 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0);
        take("mul0");

        send(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_valid("mul1", 16);
        chk_out("mul1", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        take("mul1");

        // Illegal opcode
        send(3'b111, 16'h1234, 16'h4321, 1'b0);
        wait_valid("ill", 1);
        chk_out("ill", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        take("ill");

        // i_valid held high while busy must not start a second op
        send(OP_ADD, 16'h0002, 16'h0003, 1'b1);
        wait_valid("hold_add", 1);
        for (int i = 0; i < 3; i++) begin
            chk_out("hold_add", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge i_clk);
        end
        take("hold_add");

        send(OP_MUL, 16'h0007, 16'h0009, 1'b1);
        wait_valid("hold_mul", 16);
        for (int i = 0; i < 3; i++) begin
            chk_out("hold_mul", 16'h003F, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge i_clk);
        end
        take("hold_mul");

        // Reset in the middle of a multiply
        send(OP_MUL, 16'h1234, 16'h0003, 1'b0);
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("midrst_out", 32'({o_valid, o_result}), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("midrst_ready", 32'({o_valid, o_ready}), 32'b01);
        begin
            bit leaked = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge i_clk);
                if (o_valid) leaked = 1'b1;
            end
            chk("midrst_no_result", 32'(leaked), 32'd0);
        end

        // Clean operation after the abort
        send(OP_ADD, 16'h0001, 16'hFFFF, 1'b0);
        wait_valid("post_add", 1);
        chk_out("post_add", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        take("post_add");

        send(OP_MUL, 16'h0003, 16'h0005, 1'b0);
        wait_valid("post_mul", 16);
        chk_out("post_mul", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        take("post_mul");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
